iq_dur_win: RTL and testbench
=============================

// Module: iq_dur_win
// PURPOSE
//  - Windowed aggregator for IQ residency durations from the per-entry IQ duration monitor.
//  - Consumes one tagged duration sample per cycle (fast = retired inside 128-entry AL window, slow = otherwise).
//  - Sums fast and slow durations separately over fixed-size sample windows.
//  - Hands each closed window to the AVF calc stage over a valid/ready interface.
// PARAMETERS
//  DUR_W     10  duration sample width (14-bit timestamp, 4 LSBs dropped)
//  LOG2_WIN  6   window closes after 2**LOG2_WIN total samples (fast+slow)
//  DROP_W    8   width of saturating dropped-window counter
// PORTS
//  clk        in   1               clock
//  reset_n    in   1               asynchronous active-low reset
//  dur_valid  in   1               one duration sample this cycle
//  dur_slow   in   1               0 = fast sample, 1 = slow sample
//  dur_value  in   DUR_W           duration, in timestamp units
//  flush      in   1               close current window early (partial)
//  win_valid  out  1               closed window available
//  win_ready  in   1               consumer accepts window
//  sum_fast   out  DUR_W+LOG2_WIN  sum of fast durations in window
//  sum_slow   out  DUR_W+LOG2_WIN  sum of slow durations in window
//  cnt_fast   out  LOG2_WIN+1      fast sample count
//  cnt_slow   out  LOG2_WIN+1      slow sample count
//  drop_cnt   out  DROP_W          windows discarded for backpressure, saturating
// BEHAVIOUR
//  - Reset (async assert, sync deassert by top-level): all outputs, accumulators, counts and state = 0; state = ACCUM.
//  - Accumulator stage: per-class sum/count, updated in the cycle dur_valid=1.
//  - Sum width DUR_W+LOG2_WIN; sums cannot overflow within one window.
//  - Window close: (cnt_fast+cnt_slow+dur_valid) == 2**LOG2_WIN, or flush=1 with >=1 sample incl. current.
//  - The closing sample is included in the closed window.
//  - Accumulators clear the same cycle, so a sample on the next cycle opens the next window.
//  - Flush with zero samples (none held, dur_valid=0): no-op.
//  - Output register, FSM {ACCUM, HOLD}:
//    - ACCUM: on close, load output regs with closed window; next cycle win_valid=1, state HOLD (latency 1 cycle).
//    - HOLD: outputs stable while win_valid=1 and win_ready=0.
//    - Handshake completes on win_valid & win_ready; then -> ACCUM, win_valid=0 next cycle.
//    - Close coinciding with accept in HOLD: load new window, stay HOLD, win_valid stays 1 (back-to-back).
//    - Close in HOLD without accept: new window discarded; drop_cnt += 1, saturating at all-ones; accumulators still clear.
//    - Sampling continues in HOLD (accumulators independent of output reg).
//  - win_valid never deasserts without a handshake; outputs change only at load.
//  - Reset mid-window or mid-HOLD: held and partial data lost; no output.
// CONFIGURATION
//  - IQ_DUR_WIN_MAX_EN defined: adds ports max_fast/max_slow (out, DUR_W).
//    - Per-window maximum of each class, 0 if the class is empty.
//    - Loaded with the sums, reset 0.
//  - IQ_DUR_WIN_MAX_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  - avfcl_pkg: DURATION_WIDTH (=10), AL_FAST_WINDOW (=128).
//  - avfcl_pkg: typedef dur_t; typedef struct win_rec_t {sum_fast, sum_slow, cnt_fast, cnt_slow[, max_*]}.
//  - avfcl_pkg: enum win_state_e {ACCUM, HOLD}.
//  - Sub-module iq_dur_acc: one per class (instantiated twice).
//    - Sum/count (and optional max) accumulator with sync clear and load-enable.
//  - Close logic, FSM and output register stay in iq_dur_win.
// TESTING
//  - 64 fast samples of 5, win_ready=1 -> one win_valid pulse 1 cycle after 64th; sum_fast=320, cnt_fast=64, slow=0.
//  - Alternating fast 3 / slow 7, 64 samples -> sum_fast=96, sum_slow=224, cnt_fast=cnt_slow=32.
//  - 10 fast samples of 1023 then flush -> sum_fast=10230, cnt_fast=10; flush again with no samples -> no win_valid.
//  - win_ready=0, 3 full windows -> first window held unchanged; drop_cnt=2; after ready, 4th window delivered normally.
//  - Close and accept same cycle in HOLD -> win_valid stays 1, new data next cycle, drop_cnt unchanged.
//  - reset_n pulsed low mid-HOLD -> win_valid=0 immediately, counts 0; next window counts from zero.
//  - With IQ_DUR_WIN_MAX_EN: fast {4,900,12} + flush -> max_fast=900, max_slow=0.

Source files
------------

// File: rtl/avfcl_pkg.sv
// Shared widths, window record and FSM encoding for the IQ duration window aggregator.
// Optional per-window maximum fields appear when IQ_DUR_WIN_MAX_EN is defined.
package avfcl_pkg;

  localparam int DURATION_WIDTH = 10;
  localparam int AL_FAST_WINDOW = 128;
  localparam int WIN_LOG2_DEF   = 6;
  localparam int DROP_W_DEF     = 8;

  typedef logic [DURATION_WIDTH-1:0] dur_t;

  typedef struct packed {
    logic [DURATION_WIDTH+WIN_LOG2_DEF-1:0] sum_fast;
    logic [DURATION_WIDTH+WIN_LOG2_DEF-1:0] sum_slow;
    logic [WIN_LOG2_DEF:0]                  cnt_fast;
    logic [WIN_LOG2_DEF:0]                  cnt_slow;
`ifdef IQ_DUR_WIN_MAX_EN
    dur_t                                   max_fast;
    dur_t                                   max_slow;
`endif
  } win_rec_t;

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} win_state_e;

endpackage

// File: rtl/iq_dur_win_if.sv
// Sample stream in, closed-window record out. Handshake: a window transfers on every
// cycle where win_valid and win_ready are both 1; win_valid holds with stable data until then.
interface iq_dur_win_if #(
  parameter int DUR_W    = 10,
  parameter int LOG2_WIN = 6,
  parameter int DROP_W   = 8
);
  logic                      dur_valid;
  logic                      dur_slow;
  logic [DUR_W-1:0]          dur_value;
  logic                      flush;
  logic                      win_valid;
  logic                      win_ready;
  logic [DUR_W+LOG2_WIN-1:0] sum_fast;
  logic [DUR_W+LOG2_WIN-1:0] sum_slow;
  logic [LOG2_WIN:0]         cnt_fast;
  logic [LOG2_WIN:0]         cnt_slow;
  logic [DROP_W-1:0]         drop_cnt;
`ifdef IQ_DUR_WIN_MAX_EN
  logic [DUR_W-1:0]          max_fast;
  logic [DUR_W-1:0]          max_slow;
`endif

  modport master (
    output dur_valid, dur_slow, dur_value, flush, win_ready,
    input  win_valid, sum_fast, sum_slow, cnt_fast, cnt_slow, drop_cnt
`ifdef IQ_DUR_WIN_MAX_EN
    , input max_fast, max_slow
`endif
  );

  modport slave (
    input  dur_valid, dur_slow, dur_value, flush, win_ready,
    output win_valid, sum_fast, sum_slow, cnt_fast, cnt_slow, drop_cnt
`ifdef IQ_DUR_WIN_MAX_EN
    , output max_fast, max_slow
`endif
  );
endinterface

// File: rtl/iq_dur_acc.sv
// Per-class sum/count (and, with IQ_DUR_WIN_MAX_EN, maximum) accumulator.
// The *_o totals already include the current sample so a closing window can capture it.
module iq_dur_acc
  import avfcl_pkg::*;
#(
  parameter int DUR_W    = DURATION_WIDTH,
  parameter int LOG2_WIN = WIN_LOG2_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [DUR_W-1:0]          val_i,
  output logic [DUR_W+LOG2_WIN-1:0] sum_o,
  output logic [LOG2_WIN:0]         cnt_o,
  output logic [LOG2_WIN:0]         cnt_held_o
`ifdef IQ_DUR_WIN_MAX_EN
  , output logic [DUR_W-1:0]        max_o
`endif
);
  localparam int SUM_W = DUR_W + LOG2_WIN;

  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [LOG2_WIN:0]   cnt_q, cnt_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (en_i) begin
      sum_d = sum_q + {{LOG2_WIN{1'b0}}, val_i};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
    end
  end

  assign sum_o      = sum_d;
  assign cnt_o      = cnt_d;
  assign cnt_held_o = cnt_q;

`ifdef IQ_DUR_WIN_MAX_EN
  logic [DUR_W-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (en_i && (val_i > max_q)) max_d = val_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   max_q <= '0;
    else if (clr_i) max_q <= '0;
    else            max_q <= max_d;
  end

  assign max_o = max_d;
`endif
endmodule

// File: rtl/iq_dur_win.sv
// Windowed fast/slow IQ duration aggregator with a one-deep output register and drop counter.
// Defining IQ_DUR_WIN_MAX_EN adds per-window max_fast/max_slow to the output record.
module iq_dur_win
  import avfcl_pkg::*;
#(
  parameter int DUR_W    = DURATION_WIDTH,
  parameter int LOG2_WIN = WIN_LOG2_DEF,
  parameter int DROP_W   = DROP_W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  iq_dur_win_if.slave    bus,
  output logic [0:0]     state_dbg_o
);
  localparam int SUM_W = DUR_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam int TOT_W = CNT_W + 1;
  localparam logic [0:0] ST_ACCUM = ACCUM;
  localparam logic [0:0] ST_HOLD  = HOLD;

  logic             take_fast, take_slow;
  logic [SUM_W-1:0] acc_sum_f, acc_sum_s;
  logic [CNT_W-1:0] acc_cnt_f, acc_cnt_s, held_cnt_f, held_cnt_s;
  logic [TOT_W-1:0] total;
  logic             close_win, load, drop_inc;
  logic [0:0]       state_q, state_d;
  logic [SUM_W-1:0] sum_fast_q, sum_slow_q;
  logic [CNT_W-1:0] cnt_fast_q, cnt_slow_q;
  logic [DROP_W-1:0] drop_q;

  assign take_fast = bus.dur_valid & ~bus.dur_slow;
  assign take_slow = bus.dur_valid &  bus.dur_slow;

`ifdef IQ_DUR_WIN_MAX_EN
  logic [DUR_W-1:0] acc_max_f, acc_max_s, max_fast_q, max_slow_q;
`endif

  iq_dur_acc #(.DUR_W(DUR_W), .LOG2_WIN(LOG2_WIN)) u_acc_fast (
    .clk(clk), .reset_n(reset_n), .en_i(take_fast), .clr_i(close_win),
    .val_i(bus.dur_value), .sum_o(acc_sum_f), .cnt_o(acc_cnt_f), .cnt_held_o(held_cnt_f)
`ifdef IQ_DUR_WIN_MAX_EN
    , .max_o(acc_max_f)
`endif
  );

  iq_dur_acc #(.DUR_W(DUR_W), .LOG2_WIN(LOG2_WIN)) u_acc_slow (
    .clk(clk), .reset_n(reset_n), .en_i(take_slow), .clr_i(close_win),
    .val_i(bus.dur_value), .sum_o(acc_sum_s), .cnt_o(acc_cnt_s), .cnt_held_o(held_cnt_s)
`ifdef IQ_DUR_WIN_MAX_EN
    , .max_o(acc_max_s)
`endif
  );

  // A flush only closes a window that holds at least one sample, counting the current one.
  assign total     = {1'b0, held_cnt_f} + {1'b0, held_cnt_s} + TOT_W'(bus.dur_valid);
  assign close_win = (total == TOT_W'(1 << LOG2_WIN)) || (bus.flush && (total != '0));

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (close_win) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      default: begin
        if (close_win && bus.win_ready) load = 1'b1;
        else if (close_win)             drop_inc = 1'b1;
        else if (bus.win_ready)         state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_ACCUM;
      sum_fast_q <= '0;
      sum_slow_q <= '0;
      cnt_fast_q <= '0;
      cnt_slow_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        sum_fast_q <= acc_sum_f;
        sum_slow_q <= acc_sum_s;
        cnt_fast_q <= acc_cnt_f;
        cnt_slow_q <= acc_cnt_s;
      end
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
    end
  end

`ifdef IQ_DUR_WIN_MAX_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_fast_q <= '0;
      max_slow_q <= '0;
    end else if (load) begin
      max_fast_q <= acc_max_f;
      max_slow_q <= acc_max_s;
    end
  end

  assign bus.max_fast = max_fast_q;
  assign bus.max_slow = max_slow_q;
`endif

  assign bus.win_valid = (state_q == ST_HOLD);
  assign bus.sum_fast  = sum_fast_q;
  assign bus.sum_slow  = sum_slow_q;
  assign bus.cnt_fast  = cnt_fast_q;
  assign bus.cnt_slow  = cnt_slow_q;
  assign bus.drop_cnt  = drop_q;
  assign state_dbg_o   = state_q;
endmodule

// File: tb/tb_iq_dur_win.sv
// Directed bench for iq_dur_win: full windows, flush, backpressure drops, back-to-back, reset.
// Max checks run only when IQ_DUR_WIN_MAX_EN is defined.
module tb_iq_dur_win;
  logic       clk;
  logic       reset_n;
  logic [0:0] state_dbg;
  int         checks_n;
  int         errors_n;
  int         accept_n;

  iq_dur_win_if #(.DUR_W(10), .LOG2_WIN(6), .DROP_W(8)) bus ();

  iq_dur_win #(.DUR_W(10), .LOG2_WIN(6), .DROP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .state_dbg_o(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset_n && bus.win_valid && bus.win_ready) accept_n++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic slow, input logic [9:0] val);
    bus.dur_valid = 1'b1;
    bus.dur_slow  = slow;
    bus.dur_value = val;
    step();
    bus.dur_valid = 1'b0;
    bus.dur_slow  = 1'b0;
    bus.dur_value = '0;
  endtask

  task automatic send_n(input int n, input logic slow, input logic [9:0] val);
    for (int i = 0; i < n; i++) send(slow, val);
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
  endtask

  initial begin
    checks_n      = 0;
    errors_n      = 0;
    accept_n      = 0;
    reset_n       = 1'b0;
    bus.dur_valid = 1'b0;
    bus.dur_slow  = 1'b0;
    bus.dur_value = '0;
    bus.flush     = 1'b0;
    bus.win_ready = 1'b1;
    step();
    step();
    check("rst_valid", 32'(bus.win_valid), 0);
    check("rst_sum_fast", 32'(bus.sum_fast), 0);
    check("rst_cnt_fast", 32'(bus.cnt_fast), 0);
    check("rst_drop", 32'(bus.drop_cnt), 0);
    check("rst_state", 32'(state_dbg), 0);
    reset_n = 1'b1;
    step();

    // 64 fast samples of 5
    send_n(63, 1'b0, 10'd5);
    check("t1_pre_valid", 32'(bus.win_valid), 0);
    send(1'b0, 10'd5);
    check("t1_valid", 32'(bus.win_valid), 1);
    check("t1_sum_fast", 32'(bus.sum_fast), 320);
    check("t1_cnt_fast", 32'(bus.cnt_fast), 64);
    check("t1_sum_slow", 32'(bus.sum_slow), 0);
    check("t1_cnt_slow", 32'(bus.cnt_slow), 0);
    step();
    check("t1_valid_drop", 32'(bus.win_valid), 0);
    check("t1_accepts", 32'(accept_n), 1);

    // alternating fast 3 / slow 7
    for (int i = 0; i < 32; i++) begin
      send(1'b0, 10'd3);
      send(1'b1, 10'd7);
    end
    check("t2_valid", 32'(bus.win_valid), 1);
    check("t2_sum_fast", 32'(bus.sum_fast), 96);
    check("t2_sum_slow", 32'(bus.sum_slow), 224);
    check("t2_cnt_fast", 32'(bus.cnt_fast), 32);
    check("t2_cnt_slow", 32'(bus.cnt_slow), 32);
    step();

    // partial window via flush, then empty flush
    send_n(10, 1'b0, 10'd1023);
    check("t3_pre_valid", 32'(bus.win_valid), 0);
    do_flush();
    check("t3_valid", 32'(bus.win_valid), 1);
    check("t3_sum_fast", 32'(bus.sum_fast), 10230);
    check("t3_cnt_fast", 32'(bus.cnt_fast), 10);
    check("t3_cnt_slow", 32'(bus.cnt_slow), 0);
    step();
    do_flush();
    check("t3_empty_flush", 32'(bus.win_valid), 0);
    step();
    check("t3_empty_flush2", 32'(bus.win_valid), 0);
    check("t3_accepts", 32'(accept_n), 3);

    // backpressure: three windows while stalled
    bus.win_ready = 1'b0;
    send_n(64, 1'b0, 10'd1);
    send_n(64, 1'b0, 10'd2);
    send_n(64, 1'b0, 10'd3);
    check("t4_valid", 32'(bus.win_valid), 1);
    check("t4_sum_fast", 32'(bus.sum_fast), 64);
    check("t4_cnt_fast", 32'(bus.cnt_fast), 64);
    check("t4_drop", 32'(bus.drop_cnt), 2);
    bus.win_ready = 1'b1;
    step();
    check("t4_release", 32'(bus.win_valid), 0);
    send_n(64, 1'b0, 10'd4);
    check("t4_w4_valid", 32'(bus.win_valid), 1);
    check("t4_w4_sum", 32'(bus.sum_fast), 256);
    check("t4_w4_drop", 32'(bus.drop_cnt), 2);
    step();

    // close coinciding with accept
    bus.win_ready = 1'b0;
    send_n(64, 1'b0, 10'd1);
    send_n(63, 1'b0, 10'd2);
    check("t5_hold_sum", 32'(bus.sum_fast), 64);
    bus.win_ready = 1'b1;
    send(1'b0, 10'd2);
    check("t5_valid", 32'(bus.win_valid), 1);
    check("t5_sum_fast", 32'(bus.sum_fast), 128);
    check("t5_drop", 32'(bus.drop_cnt), 2);
    check("t5_state", 32'(state_dbg), 1);
    step();
    check("t5_valid_drop", 32'(bus.win_valid), 0);

    // reset while holding a window with a partial one behind it
    bus.win_ready = 1'b0;
    send_n(64, 1'b0, 10'd1);
    send_n(5, 1'b1, 10'd9);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_valid", 32'(bus.win_valid), 0);
    check("t6_cnt_fast", 32'(bus.cnt_fast), 0);
    check("t6_sum_fast", 32'(bus.sum_fast), 0);
    check("t6_drop", 32'(bus.drop_cnt), 0);
    step();
    reset_n       = 1'b1;
    bus.win_ready = 1'b1;
    step();
    send_n(63, 1'b0, 10'd3);
    check("t6_pre_valid", 32'(bus.win_valid), 0);
    send(1'b0, 10'd3);
    check("t6_post_valid", 32'(bus.win_valid), 1);
    check("t6_post_sum", 32'(bus.sum_fast), 192);
    check("t6_post_slow", 32'(bus.cnt_slow), 0);
    step();

`ifdef IQ_DUR_WIN_MAX_EN
    send(1'b0, 10'd4);
    send(1'b0, 10'd900);
    send(1'b0, 10'd12);
    do_flush();
    check("mx_valid", 32'(bus.win_valid), 1);
    check("mx_sum_fast", 32'(bus.sum_fast), 916);
    check("mx_max_fast", 32'(bus.max_fast), 900);
    check("mx_max_slow", 32'(bus.max_slow), 0);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end
endmodule
